// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: 2W/W -> W-bit quotient and remainder,
// one quotient bit per clock. Optional ABORT port under `DIV_ABORT_EN`.
module seq_divider #(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
`ifdef DIV_ABORT_EN
  input  logic           ABORT,
`endif
  input  logic [2*W-1:0] DIVIDEND,
  input  logic [W-1:0]   DIVISOR,
  output logic [W-1:0]   QUOTIENT,
  output logic [W-1:0]   REMAINDER,
  output logic           BUSY,
  output logic           DONE,
  output logic           DIV_ZERO,
  output logic           OVERFLOW
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t        state, state_n;
  logic [W:0]    r, r_n;
  logic [W-1:0]  q, q_n;
  logic [W-1:0]  dvs, dvs_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  quo_n, rem_n;
  logic          dz_n, ov_n;
  logic [W:0]    sh;
  logic [W-1:0]  qs;

  assign BUSY = (state == CALC);
  assign DONE = (state == FIN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      cnt       <= '0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
      DIV_ZERO  <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      r         <= r_n;
      q         <= q_n;
      dvs       <= dvs_n;
      cnt       <= cnt_n;
      QUOTIENT  <= quo_n;
      REMAINDER <= rem_n;
      DIV_ZERO  <= dz_n;
      OVERFLOW  <= ov_n;
    end
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    q_n     = q;
    dvs_n   = dvs;
    cnt_n   = cnt;
    quo_n   = QUOTIENT;
    rem_n   = REMAINDER;
    dz_n    = DIV_ZERO;
    ov_n    = OVERFLOW;
    sh      = {r[W-1:0], q[W-1]};
    qs      = {q[W-2:0], 1'b0};
    if (sh >= {1'b0, dvs}) begin
      sh    = sh - {1'b0, dvs};
      qs[0] = 1'b1;
    end
    case (state)
      IDLE, FIN: begin
        state_n = IDLE;
        if (START) begin
          if (DIVISOR == '0) begin
            state_n = FIN;
            quo_n   = '1;
            rem_n   = DIVIDEND[W-1:0];
            dz_n    = 1'b1;
            ov_n    = 1'b0;
          end else if (DIVIDEND[2*W-1:W] >= DIVISOR) begin
            // Quotient cannot fit in W bits
            state_n = FIN;
            quo_n   = '1;
            rem_n   = '0;
            dz_n    = 1'b0;
            ov_n    = 1'b1;
          end else begin
            state_n = CALC;
            r_n     = {1'b0, DIVIDEND[2*W-1:W]};
            q_n     = DIVIDEND[W-1:0];
            dvs_n   = DIVISOR;
            cnt_n   = CW'(W);
            dz_n    = 1'b0;
            ov_n    = 1'b0;
          end
        end
      end
      CALC: begin
`ifdef DIV_ABORT_EN
        if (ABORT) begin
          state_n = IDLE;
        end else begin
`endif
          r_n   = sh;
          q_n   = qs;
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_n = FIN;
            quo_n   = qs;
            rem_n   = sh[W-1:0];
          end
`ifdef DIV_ABORT_EN
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider against an
// arithmetic reference model.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] held_q = 8'd0;
  logic [7:0] held_r = 8'd0;

  seq_divider #(.W(8)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .START(start),
`ifdef DIV_ABORT_EN
    .ABORT(abort),
`endif
    .DIVIDEND(dividend),
    .DIVISOR(divisor),
    .QUOTIENT(quotient),
    .REMAINDER(remainder),
    .BUSY(busy),
    .DONE(done),
    .DIV_ZERO(div_zero),
    .OVERFLOW(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division plus the two error rules
  task automatic model(input logic [15:0] dd, input logic [7:0] ds,
                       output logic [7:0] eq, output logic [7:0] er,
                       output logic ez, output logic eo, output int lat);
    int a, b;
    a = int'(dd);
    b = int'(ds);
    ez = 1'b0;
    eo = 1'b0;
    if (b == 0) begin
      eq = 8'hff; er = dd[7:0]; ez = 1'b1; lat = 1;
    end else if (a / 256 >= b) begin
      eq = 8'hff; er = 8'h00; eo = 1'b1; lat = 1;
    end else begin
      eq = 8'(a / b); er = 8'(a % b); lat = 9;
    end
  endtask

  task automatic wait_done(input string tag, output int n,
                           output int busy_n);
    n = 1;
    busy_n = 0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      chk({tag, ":held_q"}, 32'(quotient), 32'(held_q));
      chk({tag, ":held_r"}, 32'(remainder), 32'(held_r));
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [15:0] dd, input logic [7:0] ds,
                       input string tag);
    logic [7:0] eq, er;
    logic ez, eo;
    int lat, n, busy_n;
    model(dd, ds, eq, er, ez, eo, lat);
    start = 1'b1;
    dividend = dd;
    divisor = ds;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tag, n, busy_n);
    chk({tag, ":latency"}, 32'(n), 32'(lat));
    chk({tag, ":busy_cycles"}, 32'(busy_n), 32'(lat - 1));
    chk({tag, ":quotient"}, 32'(quotient), 32'(eq));
    chk({tag, ":remainder"}, 32'(remainder), 32'(er));
    chk({tag, ":div_zero"}, 32'(div_zero), 32'(ez));
    chk({tag, ":overflow"}, 32'(overflow), 32'(eo));
    held_q = eq;
    held_r = er;
    @(posedge clk); #1;
    chk({tag, ":done_pulse"}, 32'(done), 32'd0);
    chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ":keep_q"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    logic [15:0] dd;
    logic [7:0]  ds;
    int n, busy_n;
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    dividend = '0;
    divisor = '0;
    #3 rst_n = 1'b0;
    #10;
    chk("rst:quotient", 32'(quotient), 32'd0);
    chk("rst:remainder", 32'(remainder), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:flags", 32'({div_zero, overflow}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'd1000, 8'd7, "normal");
    do_op(16'd65025, 8'd255, "max");
    do_op(16'd0, 8'd5, "zero_dividend");
    do_op(16'd100, 8'd0, "div_zero");
    do_op(16'h0800, 8'd8, "overflow");
    do_op(16'd1, 8'd1, "one");

    // START held high: FIN-cycle acceptance of a second request
    start = 1'b1;
    dividend = 16'd200;
    divisor = 8'd9;
    @(posedge clk); #1;
    wait_done("b2b1", n, busy_n);
    chk("b2b1:latency", 32'(n), 32'd9);
    chk("b2b1:quotient", 32'(quotient), 32'd22);
    chk("b2b1:remainder", 32'(remainder), 32'd2);
    held_q = 8'd22;
    held_r = 8'd2;
    dividend = 16'd1000;
    divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b2:busy", 32'(busy), 32'd1);
    wait_done("b2b2", n, busy_n);
    chk("b2b2:latency", 32'(n), 32'd9);
    chk("b2b2:quotient", 32'(quotient), 32'd142);
    chk("b2b2:remainder", 32'(remainder), 32'd6);
    held_q = 8'd142;
    held_r = 8'd6;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a calculation
    start = 1'b1;
    dividend = 16'd5000;
    divisor = 8'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst:quotient", 32'(quotient), 32'd0);
    chk("midrst:remainder", 32'(remainder), 32'd0);
    chk("midrst:busy", 32'(busy), 32'd0);
    chk("midrst:done", 32'(done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    held_q = 8'd0;
    held_r = 8'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("midrst:no_done", 32'({done, busy}), 32'd0);
    end
    do_op(16'd255, 8'd16, "after_rst");

`ifdef DIV_ABORT_EN
    do_op(16'd1000, 8'd7, "pre_abort");
    start = 1'b1;
    dividend = 16'd255;
    divisor = 8'd16;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort:busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("abort:no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    chk("abort:quotient", 32'(quotient), 32'd142);
    chk("abort:remainder", 32'(remainder), 32'd6);
`endif

    for (int i = 0; i < 40; i++) begin
      dd = 16'($urandom);
      ds = 8'($urandom);
      if (i % 8 == 0) ds = 8'd0;
      else if (i % 8 != 1 && ds != 8'd0) dd[15:8] = 8'($urandom % ds);
      do_op(dd, ds, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring shift-subtract divider; the inverse of the ALU's 8x8 combinational multiplier.
- Divides a 2W-bit dividend (e.g. a 16-bit product) by a W-bit divisor, giving a W-bit quotient and a W-bit remainder.
- Produces one quotient bit per clock. Sits beside the multiplier in the ALU and is driven by the control sequencer through a START/BUSY/DONE handshake.

Parameters:
- W, 8, width of divisor, quotient and remainder. Dividend is 2*W bits.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  request a division. Sampled only while BUSY=0.
- DIVIDEND  input  2W  dividend. Sampled with an accepted START.
- DIVISOR  input  W  divisor. Sampled with an accepted START.
- QUOTIENT  output  W  registered quotient. Held until the next result.
- REMAINDER  output  W  registered remainder. Held until the next result.
- BUSY  output  1  high while an iteration is in progress.
- DONE  output  1  one-cycle pulse when a result (or error result) is written.
- DIV_ZERO  output  1  sticky error flag: divisor was zero.
- OVERFLOW  output  1  sticky error flag: quotient would exceed W bits.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State goes to IDLE.
  - QUOTIENT=0, REMAINDER=0, BUSY=0, DONE=0, DIV_ZERO=0, OVERFLOW=0.
  - Internal working registers are cleared.
  - Reset mid-calculation aborts it with no DONE pulse.
- States: IDLE, CALC, FIN.
- IDLE, or FIN, with START=1 accepts a request. Checks are made in this order:
  - DIVISOR==0: go to FIN; latch QUOTIENT=all ones, REMAINDER=DIVIDEND[W-1:0], DIV_ZERO=1, OVERFLOW=0.
  - Else DIVIDEND[2W-1:W] >= DIVISOR: go to FIN; latch QUOTIENT=all ones, REMAINDER=0, OVERFLOW=1, DIV_ZERO=0.
  - Else: load partial remainder R (W+1 bits) = DIVIDEND[2W-1:W] and shift register Q = DIVIDEND[W-1:0]; clear both flags; set counter=W; go to CALC.
- CALC, each cycle:
  - R = {R[W-1:0], Q[W-1]}; Q = Q<<1.
  - If R >= DIVISOR (zero-extended): R = R - DIVISOR and Q[0]=1.
  - Decrement counter. When it reaches 0, go to FIN and latch QUOTIENT=Q and REMAINDER=R[W-1:0].
- FIN: DONE=1 for exactly this cycle. Next state is IDLE, or a new acceptance if START=1 (back-to-back operation is allowed).
- BUSY=1 exactly while in CALC. START is ignored in CALC, and DIVIDEND/DIVISOR changes during CALC have no effect (operands are captured).
- Latency, with START accepted on edge 0:
  - Normal: DONE high in cycle W+1 (cycle 9 for W=8).
  - Error cases: DONE high in cycle 1.
- QUOTIENT and REMAINDER change only on entry to FIN. They never show intermediate values.
- Flags hold until the next accepted START.
- Result invariant, no error: DIVIDEND == QUOTIENT*DIVISOR + REMAINDER, with REMAINDER < DIVISOR.
- R never exceeds 2*DIVISOR-1, so W+1 bits are sufficient.

Optional Feature:
- Macro: DIV_ABORT_EN.
- Defined: adds input port ABORT (1 bit, placed after START).
  - ABORT=1 in CALC: next state IDLE, BUSY drops next cycle, no DONE pulse.
  - QUOTIENT, REMAINDER and flags keep their previous values.
  - ABORT is ignored in IDLE and FIN. ABORT and START together in IDLE: START wins.
- Not defined: no ABORT port; every accepted request runs to FIN.

Test Plan:
- Normal: DIVIDEND=1000, DIVISOR=7, START pulse -> BUSY for 8 cycles, DONE in cycle 9, QUOTIENT=142, REMAINDER=6, flags 0.
- Max: DIVIDEND=65025, DIVISOR=255 -> QUOTIENT=255, REMAINDER=0. Also 0/5 -> QUOTIENT=0, REMAINDER=0.
- Errors:
  - 100/0 -> DONE in cycle 1, DIV_ZERO=1, QUOTIENT=255, REMAINDER=100.
  - 0x0800/8 -> DONE in cycle 1, OVERFLOW=1, QUOTIENT=255, REMAINDER=0.
- Handshake:
  - START held high continuously with changing operands: first request (200/9) gives QUOTIENT=22, REMAINDER=2.
  - Operand changes during CALC are ignored.
  - Next request accepted in the FIN cycle; its DONE arrives 9 cycles later.
- Reset mid-op: RST_N low at CALC cycle 4 -> all outputs 0 immediately, no DONE. After release, 255/16 -> QUOTIENT=15, REMAINDER=15.
- Abort (DIV_ABORT_EN): previous result 142/6, then ABORT in CALC cycle 3 of a new request -> no DONE, outputs stay 142/6, BUSY low next cycle.
